mem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single Memory block between the Processor (requester 0) and a second bus master such as a DMA/IO engine (requester 1).
- Sits between the masters and Memory in the Computer top level, and drives Memory's address, length, read/write, enable and write-data inputs.
- Uses round-robin arbitration with one transaction per grant, a bus turnaround cycle and a watchdog timeout on Memory's ready signal.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_rr_select2.sv | 15 +
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter.
// Widths here match the Memory and Processor buses.
package mem_arbiter_pkg;

   localparam int ADDR_W_DEF = 24;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      TURN   = 2'd2
   } arbState_t;

   function automatic int cntWidth(input int timeout);
      return (timeout <= 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_select2.sv
// Two-way round-robin pick; the requester not served last wins a tie.
module rr_select2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant,
   output logic grantValid
);

   always_comb begin
      grantValid = req0 | req1;
      grant      = (req0 & req1) ? ~last : req1;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one Memory port between two masters: round-robin,
// one transaction per grant, turnaround cycle, ready watchdog.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req0,
   input  logic              Req1,
   input  logic [ADDR_W-1:0] Addr0,
   input  logic [ADDR_W-1:0] Addr1,
   input  logic              Length0,
   input  logic              Length1,
   input  logic              Rd0,
   input  logic              Rd1,
   input  logic              Wr0,
   input  logic              Wr1,
   input  logic [DATA_W-1:0] WrData0,
   input  logic [DATA_W-1:0] WrData1,
   output logic              Ack0,
   output logic              Ack1,
   output logic              Err0,
   output logic              Err1,
   output logic [DATA_W-1:0] RdData0,
   output logic [DATA_W-1:0] RdData1,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemLength,
   output logic              MemRd,
   output logic              MemWr,
   output logic              MemEnable,
   output logic [DATA_W-1:0] MemWrData,
   input  logic [DATA_W-1:0] MemRdData,
   input  logic              MemRdy,
   output logic              Owner,
   output logic              Busy
);

   localparam int CW = cntWidth(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   arbState_t state, stateNext;
   logic [CW-1:0] cnt, cntNext;
   logic last, lastNext;
   logic grant, grantValid;

   logic ack0Next, ack1Next, err0Next, err1Next;
   logic ownerNext, busyNext;
   logic [DATA_W-1:0] rdData0Next, rdData1Next;
   logic [ADDR_W-1:0] memAddrNext;
   logic memLengthNext, memRdNext, memWrNext, memEnableNext;
   logic [DATA_W-1:0] memWrDataNext;

   logic selRd, selWr, selLength;
   logic [ADDR_W-1:0] selAddr;
   logic [DATA_W-1:0] selWrData;

   rr_select2 uSelect (
      .req0       (Req0),
      .req1       (Req1),
      .last       (last),
      .grant      (grant),
      .grantValid (grantValid)
   );

   always_comb begin
      selRd     = grant ? Rd1 : Rd0;
      selWr     = grant ? Wr1 : Wr0;
      selLength = grant ? Length1 : Length0;
      selAddr   = grant ? Addr1 : Addr0;
      selWrData = grant ? WrData1 : WrData0;
   end

   always_comb begin
      stateNext     = state;
      cntNext       = cnt;
      lastNext      = last;
      ack0Next      = 1'b0;
      ack1Next      = 1'b0;
      err0Next      = 1'b0;
      err1Next      = 1'b0;
      ownerNext     = Owner;
      busyNext      = Busy;
      rdData0Next   = RdData0;
      rdData1Next   = RdData1;
      memAddrNext   = MemAddr;
      memLengthNext = MemLength;
      memRdNext     = MemRd;
      memWrNext     = MemWr;
      memEnableNext = MemEnable;
      memWrDataNext = MemWrData;

      unique case (state)
         IDLE: begin
            busyNext = 1'b0;
            if (grantValid) begin
               ownerNext = grant;
               busyNext  = 1'b1;
               if (selRd == selWr) begin
                  // Illegal command: answer with an error, skip Memory
                  ack0Next  = ~grant;
                  ack1Next  = grant;
                  err0Next  = ~grant;
                  err1Next  = grant;
                  lastNext  = grant;
                  stateNext = TURN;
               end else begin
                  memAddrNext   = selAddr;
                  memLengthNext = selLength;
                  memRdNext     = selRd;
                  memWrNext     = selWr;
                  memWrDataNext = selWrData;
                  memEnableNext = 1'b1;
                  cntNext       = '0;
                  stateNext     = ACCESS;
               end
            end
         end
         ACCESS: begin
            cntNext = cnt + CW'(1);
            if (MemRdy || cnt == CNT_LAST) begin
               // Ready beats the watchdog when both land together
               if (MemRdy && MemRd) begin
                  if (Owner) rdData1Next = MemRdData;
                  else       rdData0Next = MemRdData;
               end
               ack0Next      = ~Owner;
               ack1Next      = Owner;
               err0Next      = ~Owner & ~MemRdy;
               err1Next      = Owner & ~MemRdy;
               lastNext      = Owner;
               memEnableNext = 1'b0;
               memRdNext     = 1'b0;
               memWrNext     = 1'b0;
               stateNext     = TURN;
            end
         end
         TURN: begin
            busyNext  = 1'b0;
            stateNext = IDLE;
         end
         default: begin
            busyNext      = 1'b0;
            memEnableNext = 1'b0;
            memRdNext     = 1'b0;
            memWrNext     = 1'b0;
            stateNext     = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         last      <= 1'b1;
         Ack0      <= 1'b0;
         Ack1      <= 1'b0;
         Err0      <= 1'b0;
         Err1      <= 1'b0;
         RdData0   <= '0;
         RdData1   <= '0;
         MemAddr   <= '0;
         MemLength <= 1'b0;
         MemRd     <= 1'b0;
         MemWr     <= 1'b0;
         MemEnable <= 1'b0;
         MemWrData <= '0;
         Owner     <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         last      <= lastNext;
         Ack0      <= ack0Next;
         Ack1      <= ack1Next;
         Err0      <= err0Next;
         Err1      <= err1Next;
         RdData0   <= rdData0Next;
         RdData1   <= rdData1Next;
         MemAddr   <= memAddrNext;
         MemLength <= memLengthNext;
         MemRd     <= memRdNext;
         MemWr     <= memWrNext;
         MemEnable <= memEnableNext;
         MemWrData <= memWrDataNext;
         Owner     <= ownerNext;
         Busy      <= busyNext;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level model.
// The bench plays both masters and the Memory responder.
module tb_mem_arbiter;

   localparam int TMO = 8;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        Req0 = 0, Req1 = 0;
   logic [23:0] Addr0 = 0, Addr1 = 0;
   logic        Length0 = 0, Length1 = 0;
   logic        Rd0 = 0, Rd1 = 0, Wr0 = 0, Wr1 = 0;
   logic [31:0] WrData0 = 0, WrData1 = 0;
   logic        Ack0, Ack1, Err0, Err1;
   logic [31:0] RdData0, RdData1;
   logic [23:0] MemAddr;
   logic        MemLength, MemRd, MemWr, MemEnable;
   logic [31:0] MemWrData;
   logic [31:0] MemRdData = 0;
   logic        MemRdy = 0;
   logic        Owner, Busy;

   mem_arbiter #(.ADDR_W(24), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .Clk(Clk), .Reset(Reset),
      .Req0(Req0), .Req1(Req1),
      .Addr0(Addr0), .Addr1(Addr1),
      .Length0(Length0), .Length1(Length1),
      .Rd0(Rd0), .Rd1(Rd1), .Wr0(Wr0), .Wr1(Wr1),
      .WrData0(WrData0), .WrData1(WrData1),
      .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1),
      .RdData0(RdData0), .RdData1(RdData1),
      .MemAddr(MemAddr), .MemLength(MemLength),
      .MemRd(MemRd), .MemWr(MemWr), .MemEnable(MemEnable),
      .MemWrData(MemWrData), .MemRdData(MemRdData), .MemRdy(MemRdy),
      .Owner(Owner), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   int nChecks = 0;
   int nErrors = 0;

   // Outstanding request per master, and the model's view of the arbiter
   bit          pend[2];
   bit          rqRd[2], rqWr[2], rqLen[2];
   logic [23:0] rqAddr[2];
   logic [31:0] rqData[2], rqRdVal[2];
   int          rqLat[2];
   bit          lastM;
   logic [31:0] rdModel[2];

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyInputs();
      Req0 = pend[0]; Req1 = pend[1];
      Rd0 = rqRd[0]; Rd1 = rqRd[1];
      Wr0 = rqWr[0]; Wr1 = rqWr[1];
      Length0 = rqLen[0]; Length1 = rqLen[1];
      Addr0 = rqAddr[0]; Addr1 = rqAddr[1];
      WrData0 = rqData[0]; WrData1 = rqData[1];
   endtask

   task automatic setReq(input int i, input bit rd, input bit wr,
                         input logic [23:0] a, input logic [31:0] d,
                         input int lat, input logic [31:0] rv);
      pend[i] = 1; rqRd[i] = rd; rqWr[i] = wr;
      rqLen[i] = a[0]; rqAddr[i] = a; rqData[i] = d;
      rqLat[i] = lat; rqRdVal[i] = rv;
   endtask

   task automatic randReq(input int i);
      logic [1:0] rw;
      rw = 2'($urandom_range(0, 3));
      setReq(i, rw[0], rw[1], 24'($urandom), $urandom,
             $urandom_range(1, 10), $urandom);
   endtask

   // Serve one transaction and compare it with what the rules predict
   task automatic serveOne();
      int e, en, cyc, expEn;
      bit legal, ok, got;
      e = (pend[0] && pend[1]) ? int'(!lastM) : (pend[0] ? 0 : 1);
      legal = rqRd[e] != rqWr[e];
      ok = legal && rqLat[e] <= TMO;
      expEn = !legal ? 0 : (rqLat[e] < TMO ? rqLat[e] : TMO);
      en = 0; cyc = 0; got = 0;
      applyInputs();
      while (!got && cyc < 300) begin
         @(negedge Clk);
         cyc++;
         if (Ack0 && Ack1) check("dualAck", 1, 0);
         if (Busy) check("owner", 64'(Owner), 64'(e));
         if (MemEnable) begin
            en++;
            if (en == 1) begin
               check("memAddr", 64'(MemAddr), 64'(rqAddr[e]));
               check("memWrData", 64'(MemWrData), 64'(rqData[e]));
               check("memRdWr", {MemRd, MemWr, MemLength},
                     {rqRd[e], rqWr[e], rqLen[e]});
            end
         end
         if (Ack0 || Ack1) begin
            got = 1;
            check("ackWho", {Ack1, Ack0}, (e == 1) ? 2'b10 : 2'b01);
            check("err", 64'(e ? Err1 : Err0), 64'(!ok));
            if (ok && rqRd[e]) rdModel[e] = rqRdVal[e];
            check("rdData", 64'(e ? RdData1 : RdData0), 64'(rdModel[e]));
            check("enCycles", 64'(en), 64'(expEn));
            check("ctlIdle", {MemEnable, MemRd, MemWr}, 3'b000);
         end
         MemRdy = MemEnable && (en == rqLat[e]);
         MemRdData = rqRdVal[e];
      end
      if (!got) check("ackTimeout", 0, 1);
      pend[e] = 0;
      lastM = e[0];
      applyInputs();
      @(negedge Clk);
      check("ackPulse", {Ack0, Ack1, Err0, Err1}, 4'b0000);
      check("busyAfterTurn", {Busy, MemEnable}, 2'b00);
   endtask

   initial begin
      pend = '{0, 0};
      rqRd = '{0, 0}; rqWr = '{0, 0}; rqLen = '{0, 0};
      rqAddr = '{0, 0}; rqData = '{0, 0}; rqRdVal = '{0, 0};
      rqLat = '{1, 1};
      rdModel = '{0, 0};
      lastM = 1;
      repeat (2) @(negedge Clk);
      check("resetOut", {Ack0, Ack1, Err0, Err1, MemRd, MemWr,
                         MemEnable, MemLength, Owner, Busy}, 10'd0);
      check("resetData", {RdData0, RdData1}, 64'd0);
      check("resetMem", {MemAddr, MemWrData}, 56'd0);
      Reset = 1;

      // Single read answered on the second ACCESS cycle
      setReq(0, 1, 0, 24'h000010, 32'h0, 2, 32'hDEADBEEF);
      serveOne();

      // Contention: both masters writing, four grants
      for (int k = 0; k < 4; k++) begin
         if (!pend[0]) setReq(0, 0, 1, 24'h100, 32'h11111111, 1, 0);
         if (!pend[1]) setReq(1, 0, 1, 24'h200, 32'h22222222, 1, 0);
         serveOne();
      end
      pend[1] = 0;
      applyInputs();

      // Watchdog on a write from master 1
      setReq(1, 0, 1, 24'h000ABC, 32'hCAFEF00D, 100, 0);
      serveOne();

      // Illegal Rd/Wr combination
      setReq(0, 1, 1, 24'h000020, 32'h0, 1, 0);
      serveOne();

      // Ready arriving on the last watchdog cycle
      setReq(0, 1, 0, 24'h000030, 32'h0, TMO, 32'h0BADF00D);
      serveOne();

      // Reset in the middle of an access
      setReq(1, 1, 0, 24'h000040, 32'h0, 100, 0);
      applyInputs();
      for (int c = 0; c < 10 && !MemEnable; c++) @(negedge Clk);
      check("midEnable", 64'(MemEnable), 1);
      #2 Reset = 0;
      #1;
      check("midReset", {MemEnable, Busy, Ack0, Ack1}, 4'b0000);
      pend = '{0, 0};
      applyInputs();
      rdModel = '{0, 0};
      lastM = 1;
      @(negedge Clk);
      Reset = 1;
      setReq(0, 1, 0, 24'h50, 0, 1, 32'h12345678);
      setReq(1, 1, 0, 24'h60, 0, 1, 32'h87654321);
      serveOne();
      serveOne();

      // Random traffic against the model
      for (int k = 0; k < 60; k++) begin
         for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1) randReq(i);
         if (!pend[0] && !pend[1]) randReq($urandom_range(0, 1));
         serveOne();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               nChecks, nErrors);
      $finish;
   end

endmodule
